// File: rtl/fasta_base_streamer.sv
// fasta_base_streamer: parses byte-serial ASCII FASTA; record 1 becomes the packed query, later records stream as 2-bit bases.
// Latency: a database base shows on o_vld/o_data one cycle after its byte is accepted; query length/valid one cycle after the terminating byte.
// Backpressure: o_byte_rdy is low for exactly one cycle per finished database record (SEQ_END); every other cycle a byte is accepted.
module fasta_base_streamer #(
  parameter int MAX_QUERY_LEN = 50,
  parameter int QLEN_W        = 7,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 i_byte,
  input  logic                       i_byte_vld,
  input  logic                       i_last,
  output logic                       o_byte_rdy,
  output logic [0:2*MAX_QUERY_LEN-1] o_query,
  output logic [QLEN_W-1:0]          o_query_length,
  output logic                       o_query_vld,
  output logic                       o_vld,
  output logic [1:0]                 o_data,
  output logic                       o_seq_end,
  output logic [CNT_W-1:0]           o_seq_count,
  output logic                       o_err
);

  // Query base counter must reach MAX_QUERY_LEN itself so "full" is detectable.
  localparam int              QCW  = $clog2(MAX_QUERY_LEN + 1);
  localparam logic [QCW-1:0]  QMAX = QCW'(MAX_QUERY_LEN);

  // Two end-of-record states so the pulse cycle knows whether the file is over.
  typedef enum logic [2:0] {
    WAIT_HDR,
    Q_HDR,
    Q_BODY,
    D_HDR,
    D_BODY,
    SEQ_END,
    SEQ_END_LAST,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // Byte classification
  logic [7:0] lc_byte;
  logic       is_gt;
  logic       is_lf;
  logic       is_ws;
  logic       is_base;
  logic [1:0] code;

  // FSM strobes into the datapath
  logic       take;
  logic       q_add;
  logic       q_fin;
  logic       d_emit;
  logic       bad_char;

  // Query packing
  logic [QCW-1:0] qcnt;
  logic           q_full;
  logic [QCW-1:0] q_cnt_nxt;
  logic [QCW-1:0] q_last_idx;

  // Only the end-of-record pulse cycle stalls the byte stream.
  assign o_byte_rdy = (state != SEQ_END) && (state != SEQ_END_LAST);
  assign o_seq_end  = !o_byte_rdy;
  assign take       = i_byte_vld && o_byte_rdy;

  // Decode the incoming byte: bit 5 folds upper/lower case letters together.
  always_comb begin
    lc_byte = i_byte | 8'h20;
    is_gt   = (i_byte == 8'h3E);
    is_lf   = (i_byte == 8'h0A);
    is_ws   = (i_byte == 8'h20) || (i_byte == 8'h0D) || (i_byte == 8'h09);
    is_base = 1'b1;
    code    = 2'b00;
    case (lc_byte)
      8'h61:   code = 2'b00;  // A
      8'h67:   code = 2'b01;  // G
      8'h74:   code = 2'b10;  // T
      8'h63:   code = 2'b11;  // C
      default: is_base = 1'b0;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WAIT_HDR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-byte datapath strobes.
  always_comb begin
    state_nxt = state;
    q_add     = 1'b0;
    q_fin     = 1'b0;
    d_emit    = 1'b0;
    bad_char  = 1'b0;
    case (state)
      WAIT_HDR: begin
        if (take) begin
          if (i_last) begin
            state_nxt = DONE;
          end else if (is_gt) begin
            state_nxt = Q_HDR;
          end
        end
      end
      Q_HDR: begin
        if (take) begin
          // A file ending inside the query header leaves an empty query.
          if (i_last) begin
            q_fin     = 1'b1;
            state_nxt = DONE;
          end else if (is_lf) begin
            state_nxt = Q_BODY;
          end
        end
      end
      Q_BODY: begin
        if (take) begin
          q_add    = is_base;
          bad_char = !is_base && !is_ws && !is_lf && !is_gt;
          if (i_last) begin
            q_fin     = 1'b1;
            state_nxt = DONE;
          end else if (is_gt) begin
            q_fin     = 1'b1;
            state_nxt = D_HDR;
          end
        end
      end
      D_HDR: begin
        if (take) begin
          // A header-only record still closes with a pulse.
          if (i_last) begin
            state_nxt = SEQ_END_LAST;
          end else if (is_lf) begin
            state_nxt = D_BODY;
          end
        end
      end
      D_BODY: begin
        if (take) begin
          d_emit   = is_base;
          bad_char = !is_base && !is_ws && !is_lf && !is_gt;
          if (i_last) begin
            state_nxt = SEQ_END_LAST;
          end else if (is_gt) begin
            state_nxt = SEQ_END;
          end
        end
      end
      SEQ_END:      state_nxt = D_HDR;
      SEQ_END_LAST: state_nxt = DONE;
      DONE:         state_nxt = DONE;
      default:      state_nxt = WAIT_HDR;
    endcase
  end

  // Count including a base arriving together with the terminating byte.
  assign q_full     = (qcnt == QMAX);
  assign q_cnt_nxt  = (q_add && !q_full) ? qcnt + QCW'(1) : qcnt;
  assign q_last_idx = q_cnt_nxt - QCW'(1);

  // Query packing, base streaming, record counting and sticky error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      qcnt           <= '0;
      o_query        <= '0;
      o_query_length <= '0;
      o_query_vld    <= 1'b0;
      o_vld          <= 1'b0;
      o_data         <= 2'b00;
      o_seq_count    <= '0;
      o_err          <= 1'b0;
    end else begin
      o_vld <= d_emit;
      if (d_emit) begin
        o_data <= code;
      end
      if (q_add && !q_full) begin
        for (int k = 0; k < MAX_QUERY_LEN; k++) begin
          if (qcnt == QCW'(k)) begin
            o_query[2*k +: 2] <= code;
          end
        end
        qcnt <= qcnt + QCW'(1);
      end
      if (q_fin) begin
        o_query_vld    <= 1'b1;
        o_query_length <= (q_cnt_nxt == '0) ? '0 : QLEN_W'(q_last_idx);
      end
      if (o_seq_end) begin
        o_seq_count <= o_seq_count + CNT_W'(1);
      end
      // Illegal character, base past the query capacity, or an empty query.
      if (bad_char || (q_add && q_full) || (q_fin && (q_cnt_nxt == '0))) begin
        o_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fasta_base_streamer.sv
// tb_fasta_base_streamer: drives FASTA text into fasta_base_streamer and compares against a record-level reference model.
// Latency: results are read a few cycles after the final byte is accepted.
// Backpressure: the driver holds each byte until o_byte_rdy is seen high at the accepting edge.
module tb_fasta_base_streamer;

  localparam int MQ = 50;
  localparam int QW = 7;
  localparam int CW = 16;

  logic              clk        = 1'b0;
  logic              rst        = 1'b0;
  logic [7:0]        i_byte     = 8'h00;
  logic              i_byte_vld = 1'b0;
  logic              i_last     = 1'b0;
  logic              o_byte_rdy;
  logic [0:2*MQ-1]   o_query;
  logic [QW-1:0]     o_query_length;
  logic              o_query_vld;
  logic              o_vld;
  logic [1:0]        o_data;
  logic              o_seq_end;
  logic [CW-1:0]     o_seq_count;
  logic              o_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fasta_base_streamer #(
    .MAX_QUERY_LEN (MQ),
    .QLEN_W        (QW),
    .CNT_W         (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_byte         (i_byte),
    .i_byte_vld     (i_byte_vld),
    .i_last         (i_last),
    .o_byte_rdy     (o_byte_rdy),
    .o_query        (o_query),
    .o_query_length (o_query_length),
    .o_query_vld    (o_query_vld),
    .o_vld          (o_vld),
    .o_data         (o_data),
    .o_seq_end      (o_seq_end),
    .o_seq_count    (o_seq_count),
    .o_err          (o_err)
  );

  // Observed database stream: base codes 0..3, value 4 marks an o_seq_end pulse.
  int mon_q[$];
  int rdy_bad = 0;
  int gap_bad = 0;
  bit prev_se = 1'b0;

  // Output observer on the falling edge.
  always @(negedge clk) begin
    if (o_vld) mon_q.push_back(int'(o_data));
    if (o_seq_end) mon_q.push_back(4);
    if (rst && (o_byte_rdy !== ~o_seq_end)) rdy_bad++;
    if (prev_se && o_vld) gap_bad++;
    prev_se = o_seq_end;
  end

  // Stimulus file and reference expectations
  byte             file_q[$];
  int              exp_db[$];
  logic [0:2*MQ-1] exp_query;
  int              exp_len;
  bit              exp_err;
  int              exp_cnt;

  function automatic int code_of(input byte c);
    case (c)
      8'h41, 8'h61: return 0;
      8'h47, 8'h67: return 1;
      8'h54, 8'h74: return 2;
      8'h43, 8'h63: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic put(input string s);
    for (int i = 0; i < s.len(); i++) file_q.push_back(s[i]);
  endtask

  task automatic add_body(input int n, input bit allow_bad);
    string alpha = "ACGTacgt";
    for (int i = 0; i < n; i++) begin
      file_q.push_back(alpha[$urandom_range(7)]);
      case ($urandom_range(11))
        0: file_q.push_back(8'h0A);
        1: file_q.push_back(8'h20);
        2: file_q.push_back(8'h0D);
        3: file_q.push_back(8'h09);
        4: if (allow_bad && $urandom_range(5) == 0) file_q.push_back(8'h4E);
        default: ;
      endcase
    end
    file_q.push_back(8'h0A);
  endtask

  task automatic gen_file(input int qlen, input int ndb, input bit allow_bad);
    file_q.delete();
    put(">q hdr\n");
    add_body(qlen, allow_bad);
    for (int r = 0; r < ndb; r++) begin
      put(">d\n");
      add_body($urandom_range(0, 8), allow_bad);
    end
  endtask

  // Reference: split the text into records, record 0 is the query.
  task automatic model();
    int  rec;
    bit  in_hdr;
    int  qb[$];
    byte c;
    int  cd;
    rec = -1;
    in_hdr = 1'b0;
    qb.delete();
    exp_db.delete();
    exp_err = 1'b0;
    foreach (file_q[i]) begin
      c  = file_q[i];
      cd = code_of(c);
      if (c == 8'h3E) begin
        if (rec >= 1) exp_db.push_back(4);
        rec++;
        in_hdr = 1'b1;
      end else if (rec < 0) begin
        in_hdr = 1'b0;
      end else if (in_hdr) begin
        if (c == 8'h0A) in_hdr = 1'b0;
      end else if (cd >= 0) begin
        if (rec == 0) qb.push_back(cd);
        else exp_db.push_back(cd);
      end else if (c != 8'h20 && c != 8'h0D && c != 8'h09 && c != 8'h0A) begin
        exp_err = 1'b1;
      end
    end
    if (rec >= 1) exp_db.push_back(4);
    exp_cnt = (rec >= 1) ? rec : 0;
    if (qb.size() == 0 || qb.size() > MQ) exp_err = 1'b1;
    exp_query = '0;
    for (int k = 0; k < qb.size() && k < MQ; k++) exp_query[2*k +: 2] = 2'(qb[k]);
    exp_len = (qb.size() == 0) ? 0 : ((qb.size() > MQ) ? MQ - 1 : qb.size() - 1);
  endtask

  function automatic bit stream_ok(input int m0);
    if (mon_q.size() - m0 != exp_db.size()) return 1'b0;
    for (int k = 0; k < exp_db.size(); k++) if (mon_q[m0 + k] != exp_db[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    i_byte_vld = 1'b0;
    i_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Sends file_q; i_last rides on the final byte when with_last is set.
  task automatic send(input bit with_last, input int stall_pct);
    int guard;
    bit acc;
    for (int i = 0; i < file_q.size(); i++) begin
      while (int'($urandom_range(99)) < stall_pct) begin
        i_byte_vld = 1'b0;
        i_byte = 8'($urandom);
        @(posedge clk); #1;
      end
      i_byte = file_q[i];
      i_last = with_last && (i == file_q.size() - 1);
      i_byte_vld = 1'b1;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 50) begin
        @(negedge clk);
        acc = o_byte_rdy;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        checks++;
        $display("FAIL send_timeout: byte %0d not accepted, rdy=%b required 1", i, o_byte_rdy);
        break;
      end
    end
    i_byte_vld = 1'b0;
    i_last = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (o_byte_rdy !== 1'b1) $display("FAIL reset_rdy: got %b required 1", o_byte_rdy); else passed++;
    checks++; if (o_query !== '0) $display("FAIL reset_query: got %h required 0", o_query); else passed++;
    checks++;
    if ({o_query_vld, o_vld, o_seq_end, o_err, o_data, o_query_length, o_seq_count} !== '0)
      $display("FAIL reset_outputs: qvld=%b vld=%b se=%b err=%b data=%b len=%0d cnt=%0d required all 0",
               o_query_vld, o_vld, o_seq_end, o_err, o_data, o_query_length, o_seq_count);
    else passed++;
  endtask

  task automatic test_basic();
    int m0;
    do_reset();
    file_q.delete();
    put(">q\nACGT\n>d\nGGTC\n");
    exp_db = '{1, 1, 2, 3, 4};
    m0 = mon_q.size();
    send(1'b1, 0);
    settle();
    checks++; if (o_query[0:7] !== 8'b00_11_01_10) $display("FAIL basic_query: got %b required 00110110", o_query[0:7]); else passed++;
    checks++; if (o_query[8:2*MQ-1] !== '0) $display("FAIL basic_query_unused: got %h required 0", o_query[8:2*MQ-1]); else passed++;
    checks++; if (o_query_length !== 7'd3) $display("FAIL basic_len: got %0d required 3", o_query_length); else passed++;
    checks++; if (o_query_vld !== 1'b1) $display("FAIL basic_qvld: got %b required 1", o_query_vld); else passed++;
    checks++; if (!stream_ok(m0)) $display("FAIL basic_stream: got %0d items required 1,1,2,3,end", mon_q.size() - m0); else passed++;
    checks++; if (o_seq_count !== 16'd1) $display("FAIL basic_count: got %0d required 1", o_seq_count); else passed++;
    checks++; if (o_err !== 1'b0) $display("FAIL basic_err: got %b required 0", o_err); else passed++;
  endtask

  task automatic test_two_records();
    int m0;
    int g0;
    do_reset();
    file_q.delete();
    put(">q\ngA\n>d1\naC\n>D2\nt");
    exp_db = '{0, 3, 4, 2, 4};
    m0 = mon_q.size();
    g0 = gap_bad;
    send(1'b1, 0);
    settle();
    checks++; if (!stream_ok(m0)) $display("FAIL two_stream: got %0d items required 0,3,end,2,end", mon_q.size() - m0); else passed++;
    checks++; if (gap_bad != g0) $display("FAIL two_gap: got %0d vld-after-end cycles required 0", gap_bad - g0); else passed++;
    checks++; if (o_seq_count !== 16'd2) $display("FAIL two_count: got %0d required 2", o_seq_count); else passed++;
    checks++; if (o_query_length !== 7'd1) $display("FAIL two_len: got %0d required 1", o_query_length); else passed++;
  endtask

  task automatic test_overflow();
    int m0;
    do_reset();
    gen_file(52, 1, 1'b0);
    model();
    m0 = mon_q.size();
    send(1'b1, 0);
    settle();
    checks++; if (o_query_length !== 7'd49) $display("FAIL ovf_len: got %0d required 49", o_query_length); else passed++;
    checks++; if (o_err !== 1'b1) $display("FAIL ovf_err: got %b required 1", o_err); else passed++;
    checks++; if (o_query !== exp_query) $display("FAIL ovf_query: got %h required %h", o_query, exp_query); else passed++;
    checks++; if (!stream_ok(m0)) $display("FAIL ovf_stream: got %0d items required %0d", mon_q.size() - m0, exp_db.size()); else passed++;
  endtask

  task automatic test_bad_char();
    int m0;
    do_reset();
    file_q.delete();
    put(">q\nG\n>d\nAXC\n");
    exp_db = '{0, 3, 4};
    m0 = mon_q.size();
    send(1'b1, 0);
    settle();
    checks++; if (!stream_ok(m0)) $display("FAIL bad_stream: got %0d items required 0,3,end", mon_q.size() - m0); else passed++;
    checks++; if (o_err !== 1'b1) $display("FAIL bad_err: got %b required 1", o_err); else passed++;
    checks++; if (o_seq_count !== 16'd1) $display("FAIL bad_count: got %0d required 1", o_seq_count); else passed++;
  endtask

  task automatic test_stall();
    int m0;
    int r0;
    do_reset();
    gen_file(6, 3, 1'b0);
    model();
    m0 = mon_q.size();
    r0 = rdy_bad;
    send(1'b1, 45);
    settle();
    checks++; if (!stream_ok(m0)) $display("FAIL stall_stream: got %0d items required %0d", mon_q.size() - m0, exp_db.size()); else passed++;
    checks++; if (rdy_bad != r0) $display("FAIL stall_rdy: got %0d bad rdy cycles required 0", rdy_bad - r0); else passed++;
    checks++; if (o_seq_count !== CW'(exp_cnt)) $display("FAIL stall_count: got %0d required %0d", o_seq_count, exp_cnt); else passed++;
  endtask

  task automatic test_midstream_reset();
    int m0;
    int guard;
    do_reset();
    file_q.delete();
    put(">q\nACGT\n>d\nGGT");
    m0 = mon_q.size();
    send(1'b0, 0);
    guard = 0;
    while (mon_q.size() - m0 < 3 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++; if (mon_q.size() - m0 < 3) $display("FAIL mid_bases_timeout: got %0d bases required 3", mon_q.size() - m0); else passed++;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (o_byte_rdy !== 1'b1) $display("FAIL mid_rst_rdy: got %b required 1", o_byte_rdy); else passed++;
    checks++;
    if ({o_query_vld, o_vld, o_seq_end, o_err, o_data, o_query_length, o_seq_count, o_query} !== '0)
      $display("FAIL mid_rst_outputs: qvld=%b vld=%b se=%b cnt=%0d required all 0",
               o_query_vld, o_vld, o_seq_end, o_seq_count);
    else passed++;
    #1 rst = 1'b1;
    file_q.delete();
    put(">q\nACGT\n>d\nGGTC\n");
    exp_db = '{1, 1, 2, 3, 4};
    m0 = mon_q.size();
    send(1'b1, 0);
    settle();
    checks++; if (o_query[0:7] !== 8'b00_11_01_10 || o_query_length !== 7'd3) $display("FAIL mid_query: got %b len %0d required 00110110 len 3", o_query[0:7], o_query_length); else passed++;
    checks++; if (!stream_ok(m0)) $display("FAIL mid_stream: got %0d items required 1,1,2,3,end", mon_q.size() - m0); else passed++;
    checks++; if (o_seq_count !== 16'd1 || o_err !== 1'b0) $display("FAIL mid_count_err: got cnt %0d err %b required 1 0", o_seq_count, o_err); else passed++;
  endtask

  task automatic test_random_files();
    int m0;
    int r0;
    int qlen;
    for (int t = 0; t < 8; t++) begin
      do_reset();
      qlen = ($urandom_range(4) == 0) ? int'($urandom_range(0, 55)) : int'($urandom_range(1, 20));
      gen_file(qlen, int'($urandom_range(0, 4)), 1'b1);
      model();
      m0 = mon_q.size();
      r0 = rdy_bad;
      send(1'b1, int'($urandom_range(0, 40)));
      settle();
      checks++; if (o_query_vld !== 1'b1) $display("FAIL rnd%0d_qvld: got %b required 1", t, o_query_vld); else passed++;
      checks++; if (o_query_length !== QW'(exp_len)) $display("FAIL rnd%0d_len: got %0d required %0d", t, o_query_length, exp_len); else passed++;
      checks++; if (o_query !== exp_query) $display("FAIL rnd%0d_query: got %h required %h", t, o_query, exp_query); else passed++;
      checks++; if (o_err !== exp_err) $display("FAIL rnd%0d_err: got %b required %b", t, o_err, exp_err); else passed++;
      checks++; if (o_seq_count !== CW'(exp_cnt)) $display("FAIL rnd%0d_count: got %0d required %0d", t, o_seq_count, exp_cnt); else passed++;
      checks++; if (!stream_ok(m0)) $display("FAIL rnd%0d_stream: got %0d items required %0d", t, mon_q.size() - m0, exp_db.size()); else passed++;
      checks++; if (rdy_bad != r0) $display("FAIL rnd%0d_rdy: got %0d bad rdy cycles required 0", t, rdy_bad - r0); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_records();
    test_overflow();
    test_bad_char();
    test_stall();
    test_midstream_reset();
    test_random_files();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
